ag_onehot_decoder_parity_tx: RTL and testbench

//  Transmit-side counterpart of the 9-to-4 priority encoder/parity checker.
//  - Accepts a 4-bit code (0-9) over a valid/ready handshake.
//  - Decodes the code to a 9-bit one-hot word and generates an even/odd parity bit.
//  - Serialises the word as a framed bitstream (start, 9 data, parity, stop).
//  - The frame feeds the encoder/checker side, or an external link, for loopback checking.

---
 rtl/ag_pe_pkg.sv | 28 ++
 rtl/ag_baud_tick.sv | 33 +++
 rtl/ag_onehot_decoder_parity_tx.sv | 147 ++++++++++++++
 tb/tb_ag_onehot_decoder_parity_tx.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ag_pe_pkg.sv
// Shared types and helpers for the one-hot decoder / parity transmitter.
// Frame: start bit, 9 one-hot data bits, parity bit, stop bit.
package ag_pe_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        SHIFT,
        PARITY,
        STOP
    } state_e;

    localparam int unsigned WORD_W     = 9;
    localparam int unsigned CODE_BITS  = 4;
    localparam logic [3:0]  CODE_MAX   = 4'd9;
    localparam int unsigned FRAME_BITS = 12;

    // Code k (1..9) sets bit k-1; code 0 and out-of-range codes give an all-zero word.
    function automatic logic [WORD_W-1:0] onehot_decode(input logic [CODE_BITS-1:0] code);
        logic [WORD_W-1:0] word;
        word = '0;
        if (code != 4'd0 && code <= CODE_MAX) begin
            word = WORD_W'(1) << (code - 4'd1);
        end
        return word;
    endfunction

endpackage

// File: rtl/ag_baud_tick.sv
// Bit-period pacing counter: tick pulses every CLKS_PER_BIT clocks, restarted by clr.
module ag_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (clr || tick) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ag_onehot_decoder_parity_tx.sv
// Decodes a 0-9 code to a one-hot word, adds parity and serialises it as a framed bitstream.
// Define AG_PETX_BAUD_DIV_EN to stretch every bit period to CLKS_PER_BIT clocks.
module ag_onehot_decoder_parity_tx
    import ag_pe_pkg::*;
#(
    parameter int DATA_W       = 9,
    parameter int CODE_W       = 4,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CODE_W-1:0] code_i,
    input  logic              msb_first_i,
    input  logic              odd_par_i,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_o,
    output logic              busy_o,
    output logic [DATA_W-1:0] data_o,
    output logic              par_o,
    output logic              err_o
);

    localparam logic [3:0] LAST_BIT = 4'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [3:0]        bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              par_q, par_d;
    logic              msb_q, msb_d;
    logic              ser_q, ser_d;
    logic              err_q, err_d;
    logic              accept;
    logic              tick;
    logic [DATA_W-1:0] decoded;

    function automatic logic [3:0] bit_sel(input logic msb, input logic [3:0] n);
        return msb ? (LAST_BIT - n) : n;
    endfunction

    assign in_ready = (state_q == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign decoded  = onehot_decode(code_i);

`ifdef AG_PETX_BAUD_DIV_EN
    ag_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .clr (accept),
        .tick(tick)
    );
`else
    assign tick = 1'b1;
`endif

    // ser_d always carries the value for the state being entered, so ser_o is glitch-free.
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        data_d    = data_q;
        par_d     = par_q;
        msb_d     = msb_q;
        ser_d     = ser_q;
        err_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                ser_d = 1'b1;
                if (accept) begin
                    if (code_i <= CODE_MAX) begin
                        data_d    = decoded;
                        par_d     = (^decoded) ^ odd_par_i;
                        msb_d     = msb_first_i;
                        bit_cnt_d = 4'd0;
                        ser_d     = 1'b0;
                        state_d   = START;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            START: begin
                if (tick) begin
                    bit_cnt_d = 4'd0;
                    ser_d     = data_q[bit_sel(msb_q, 4'd0)];
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        bit_cnt_d = 4'd0;
                        ser_d     = par_q;
                        state_d   = PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        ser_d     = data_q[bit_sel(msb_q, bit_cnt_q + 4'd1)];
                    end
                end
            end
            PARITY: begin
                if (tick) begin
                    ser_d   = 1'b1;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (tick) begin
                    ser_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                ser_d   = 1'b1;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= 4'd0;
            data_q    <= '0;
            par_q     <= 1'b0;
            msb_q     <= 1'b0;
            ser_q     <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            par_q     <= par_d;
            msb_q     <= msb_d;
            ser_q     <= ser_d;
            err_q     <= err_d;
        end
    end

    assign ser_o  = ser_q;
    assign busy_o = (state_q != IDLE);
    assign data_o = data_q;
    assign par_o  = par_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_ag_onehot_decoder_parity_tx.sv
// Directed self-checking bench for ag_onehot_decoder_parity_tx (default build, no baud divider).
module tb_ag_onehot_decoder_parity_tx;

    logic       clk;
    logic       rst;
    logic [3:0] code_i;
    logic       msb_first_i;
    logic       odd_par_i;
    logic       in_valid;
    logic       in_ready;
    logic       ser_o;
    logic       busy_o;
    logic [8:0] data_o;
    logic       par_o;
    logic       err_o;

    int checks;
    int failures;

    ag_onehot_decoder_parity_tx dut (
        .clk        (clk),
        .rst        (rst),
        .code_i     (code_i),
        .msb_first_i(msb_first_i),
        .odd_par_i  (odd_par_i),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ser_o      (ser_o),
        .busy_o     (busy_o),
        .data_o     (data_o),
        .par_o      (par_o),
        .err_o      (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, wanted run to finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h, wanted 0x%0h", tag, got, exp);
        end
    endtask

    // Presents one code at a negedge, lets it be accepted at the next posedge, then scrambles inputs.
    task automatic applyStimulus(input logic [3:0] code, input logic msb, input logic odd);
        @(negedge clk);
        code_i      = code;
        msb_first_i = msb;
        odd_par_i   = odd;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid    = 1'b0;
        code_i      = 4'd15;
        msb_first_i = ~msb;
        odd_par_i   = ~odd;
    endtask

    task automatic captureFrame(output logic [11:0] bits, output int busy_cnt);
        bits     = '0;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            bits = {bits[10:0], ser_o};
            busy_cnt += int'(busy_o);
        end
    endtask

    task automatic sendAndCheck(input string tag, input logic [3:0] code, input logic msb,
                                input logic odd, input logic [11:0] exp_frame,
                                input logic [8:0] exp_data, input logic exp_par);
        logic [11:0] frame;
        int          busy_cnt;
        applyStimulus(code, msb, odd);
        captureFrame(frame, busy_cnt);
        checkOutput({tag, "_frame"}, 32'(frame), 32'(exp_frame));
        checkOutput({tag, "_busy"}, 32'(busy_cnt), 32'd12);
        checkOutput({tag, "_data"}, 32'(data_o), 32'(exp_data));
        checkOutput({tag, "_par"}, 32'(par_o), 32'(exp_par));
        @(negedge clk);
        checkOutput({tag, "_ready_after"}, 32'(in_ready), 32'd1);
        checkOutput({tag, "_idle_after"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        logic [11:0] frame;
        int          busy_cnt;
        int          gap;

        checks      = 0;
        failures    = 0;
        rst         = 1'b1;
        code_i      = 4'd0;
        msb_first_i = 1'b0;
        odd_par_i   = 1'b0;
        in_valid    = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("rst_ready", 32'(in_ready), 32'd0);
        checkOutput("rst_ser", 32'(ser_o), 32'd1);
        checkOutput("rst_busy", 32'(busy_o), 32'd0);
        checkOutput("rst_data", 32'(data_o), 32'd0);
        checkOutput("rst_par", 32'(par_o), 32'd0);
        checkOutput("rst_err", 32'(err_o), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("post_rst_ready", 32'(in_ready), 32'd1);

        sendAndCheck("t1_code4", 4'd4, 1'b0, 1'b0, 12'b0000_1000_0011, 9'b000001000, 1'b1);
        sendAndCheck("t2_code9", 4'd9, 1'b1, 1'b1, 12'b0100_0000_0001, 9'b100000000, 1'b0);

        // Invalid code: handshake completes, one-cycle error, nothing sent, word held.
        applyStimulus(4'd12, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("t4_err", 32'(err_o), 32'd1);
        checkOutput("t4_ser", 32'(ser_o), 32'd1);
        checkOutput("t4_ready", 32'(in_ready), 32'd1);
        checkOutput("t4_busy", 32'(busy_o), 32'd0);
        checkOutput("t4_data", 32'(data_o), 32'h100);
        checkOutput("t4_par", 32'(par_o), 32'd0);
        @(negedge clk);
        checkOutput("t4_err_drop", 32'(err_o), 32'd0);
        checkOutput("t4_ser_idle", 32'(ser_o), 32'd1);

        sendAndCheck("t3_code0", 4'd0, 1'b0, 1'b1, 12'b0000_0000_0011, 9'b000000000, 1'b1);

        // Back-to-back: in_valid stays high, the second code waits for in_ready.
        @(negedge clk);
        code_i      = 4'd2;
        msb_first_i = 1'b0;
        odd_par_i   = 1'b0;
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        code_i = 4'd3;
        gap    = 0;
        for (int n = 1; n <= 20; n++) begin
            @(negedge clk);
            if (n == 1) checkOutput("t5_first_data", 32'(data_o), 32'h002);
            if (in_ready) begin
                gap = n;
                break;
            end
        end
        checkOutput("t5_accept_gap", 32'(gap), 32'd13);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        captureFrame(frame, busy_cnt);
        checkOutput("t5_second_frame", 32'(frame), 32'(12'b0001_0000_0011));
        checkOutput("t5_second_data", 32'(data_o), 32'h004);
        @(negedge clk);

        // Reset during cycle 6 of a frame (LSB-first code 1, data bit 4 = 0 on the line).
        applyStimulus(4'd1, 1'b0, 1'b0);
        repeat (6) @(negedge clk);
        checkOutput("t6_pre_ser", 32'(ser_o), 32'd0);
        checkOutput("t6_pre_busy", 32'(busy_o), 32'd1);
        rst = 1'b1;
        #1;
        checkOutput("t6_abort_ser", 32'(ser_o), 32'd1);
        checkOutput("t6_abort_busy", 32'(busy_o), 32'd0);
        checkOutput("t6_abort_ready", 32'(in_ready), 32'd0);
        checkOutput("t6_abort_data", 32'(data_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_ready", 32'(in_ready), 32'd1);
        sendAndCheck("t6_code7", 4'd7, 1'b1, 1'b0, 12'b0001_0000_0011, 9'b001000000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
